// File: rtl/obstacle_spawner_pkg.sv
// Shared types and constants for the obstacle spawner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package obstacle_spawner_pkg;

  // Motion FSM states
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int POS_W_DEF = 12;
  localparam int FRAC_DEF  = 2;

  // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (right-shift form)
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Whole pixels to fixed point with `frac` fractional bits
  function automatic int px_to_fixed(input int px, input int frac);
    return px * (1 << frac);
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// Free-running Galois LFSR supplying spawn-gap jitter; never reaches zero from a nonzero seed.
// Latency: q is registered and advances by one step every clock.
// Backpressure: none; it always advances.
//
// Ports: clk, rst (async active-high, loads SEED), q (current LFSR state).
module spawn_lfsr
  import obstacle_spawner_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[WIDTH-1:1]} ^ (q_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Moves N_OBST obstacle slots by dino_speed once per tick, despawns them past the right edge,
// spawns new ones after a randomised gap, and shortens the tick period over time.
// Latency: outputs registered; positions and obst_sync appear the cycle after the tick. No backpressure; game_over freezes all motion.
//
// Ports: clk, rst (async active-high), game_over (freeze level), dino_speed (unsigned fixed-point step),
//        obst_pos (integer part per slot, slot k at [k*POS_W +: POS_W]), obst_active (per-slot valid),
//        obst_sync (one-cycle pulse after each update), tick_period (current clocks per tick).
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int          N_OBST      = 4,
  parameter int          POS_W       = POS_W_DEF,
  parameter int          FRAC        = FRAC_DEF,
  parameter int          TICK_INIT   = 200000,
  parameter int          TICK_MIN    = 50000,
  parameter int          TICK_STEP   = 10000,
  parameter int          RAMP_PERIOD = 180000000,
  parameter int          INIT_X      = 300,
  parameter int          SPAWN_X     = -50,
  parameter int          DESPAWN_X   = 1074,
  parameter int          GAP_MIN     = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_over,
  input  logic [POS_W+FRAC-1:0]   dino_speed,
  output logic [N_OBST*POS_W-1:0] obst_pos,
  output logic [N_OBST-1:0]       obst_active,
  output logic                    obst_sync,
  output logic [31:0]             tick_period
);

  localparam int PW = POS_W + FRAC;

  localparam logic signed [PW-1:0] INIT_FX    = PW'(px_to_fixed(INIT_X, FRAC));
  localparam logic signed [PW-1:0] SPAWN_FX   = PW'(px_to_fixed(SPAWN_X, FRAC));
  localparam logic signed [PW-1:0] DESPAWN_FX = PW'(px_to_fixed(DESPAWN_X, FRAC));

  localparam logic [31:0] TICK_INIT_U = 32'(TICK_INIT);
  localparam logic [31:0] TICK_MIN_U  = 32'(TICK_MIN);
  localparam logic [31:0] TICK_STEP_U = 32'(TICK_STEP);
  localparam logic [31:0] RAMP_LAST   = 32'(RAMP_PERIOD - 1);
  localparam logic [15:0] GAP_MIN_U   = 16'(GAP_MIN);

  // State
  state_e                     state_q, state_d;
  logic [N_OBST-1:0][PW-1:0]  pos_q, pos_d;
  logic [N_OBST-1:0]          act_q, act_d;
  logic [15:0]                gap_q, gap_d;
  logic [31:0]                tick_cnt_q, tick_cnt_d;
  logic [31:0]                ramp_cnt_q, ramp_cnt_d;
  logic [31:0]                period_q, period_d;
  logic                       sync_q, sync_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr_hi;

  // Combinational helpers
  logic              run_go;
  logic              tick;
  logic              free_found;
  logic [N_OBST-1:0] spawn_oh;
  logic [PW-1:0]     nx;

  spawn_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low byte feeds the gap jitter
  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:8];

  // Lowest-index slot that is free before this tick; computed from the
  // pre-tick flags so a slot despawned on this tick cannot be reused until the next one.
  always_comb begin
    free_found = 1'b0;
    spawn_oh   = '0;
    for (int k = 0; k < N_OBST; k++) begin
      if (!act_q[k] && !free_found) begin
        spawn_oh[k] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  // A game_over arriving on a tick cycle suppresses the tick, since motion only counts when !game_over.
  assign run_go = (state_q == ST_RUN) && !game_over;
  assign tick   = run_go && (tick_cnt_q >= period_q - 32'd1);

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    act_d      = act_q;
    gap_d      = gap_q;
    tick_cnt_d = tick_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    period_d   = period_q;
    sync_d     = 1'b0;
    nx         = '0;

    case (state_q)
      ST_INIT: begin
        for (int k = 0; k < N_OBST; k++) begin
          pos_d[k] = SPAWN_FX;
          act_d[k] = 1'b0;
        end
        pos_d[0] = INIT_FX;
        act_d[0] = 1'b1;
        gap_d    = GAP_MIN_U;
        state_d  = ST_RUN;
      end

      ST_RUN: begin
        if (game_over) begin
          state_d = ST_HALT;
        end else begin
          // Speed ramp; the tick decision above used the old period, so a
          // ramp landing on a tick only affects the following interval.
          if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = '0;
            period_d   = (period_q >= TICK_MIN_U + TICK_STEP_U) ? (period_q - TICK_STEP_U)
                                                                 : TICK_MIN_U;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 32'd1;
          end

          if (tick) begin
            tick_cnt_d = '0;
            sync_d     = 1'b1;

            for (int k = 0; k < N_OBST; k++) begin
              if (act_q[k]) begin
                nx = pos_q[k] + dino_speed;
                // Signed >= so that a large step overshooting the edge is still caught
                if ($signed(nx) >= DESPAWN_FX) begin
                  act_d[k] = 1'b0;
                  pos_d[k] = SPAWN_FX;
                end else begin
                  pos_d[k] = nx;
                end
              end
            end

            if (gap_q != 16'd0) begin
              gap_d = gap_q - 16'd1;
            end else if (free_found) begin
              for (int k = 0; k < N_OBST; k++) begin
                if (spawn_oh[k]) begin
                  act_d[k] = 1'b1;
                  pos_d[k] = SPAWN_FX;
                end
              end
              gap_d = GAP_MIN_U + {8'd0, lfsr_q[7:0]};
            end
            // else: every slot busy, gap stays 0 and the spawn retries next tick
          end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
          end
        end
      end

      ST_HALT: begin
        if (!game_over) state_d = ST_RUN;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      pos_q      <= {N_OBST{SPAWN_FX}};
      act_q      <= '0;
      gap_q      <= GAP_MIN_U;
      tick_cnt_q <= '0;
      ramp_cnt_q <= '0;
      period_q   <= TICK_INIT_U;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      act_q      <= act_d;
      gap_q      <= gap_d;
      tick_cnt_q <= tick_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      period_q   <= period_d;
      sync_q     <= sync_d;
    end
  end

  always_comb begin
    obst_pos = '0;
    for (int k = 0; k < N_OBST; k++) begin
      obst_pos[k*POS_W +: POS_W] = pos_q[k][PW-1:FRAC];
    end
  end

  assign obst_active = act_q;
  assign obst_sync   = sync_q;
  assign tick_period = period_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: directed scenarios plus randomised
// speed/freeze/reset traffic compared every cycle against a rule-level reference model.
// Small parameters keep ticks, ramps and gaps short.
module tb_obstacle_spawner;

  localparam int N   = 4;
  localparam int PWI = 12;
  localparam int FR  = 2;
  localparam logic [11:0] NEG50 = 12'hFCE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              game_over = 1'b0;
  logic [PWI+FR-1:0] dino_speed = '0;
  logic [N*PWI-1:0]  obst_pos;
  logic [N-1:0]      obst_active;
  logic              obst_sync;
  logic [31:0]       tick_period;

  int n_cmp = 0;
  int n_bad = 0;

  obstacle_spawner #(
    .N_OBST(N), .POS_W(PWI), .FRAC(FR),
    .TICK_INIT(4), .TICK_MIN(2), .TICK_STEP(1), .RAMP_PERIOD(40),
    .INIT_X(300), .SPAWN_X(-50), .DESPAWN_X(1074), .GAP_MIN(2),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .game_over(game_over), .dino_speed(dino_speed),
    .obst_pos(obst_pos), .obst_active(obst_active), .obst_sync(obst_sync),
    .tick_period(tick_period)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (fixed-point ints, quarter pixels) ----------------
  int       m_pos [N];
  bit [3:0] m_act;
  int       m_gap, m_tcnt, m_rcnt, m_period, m_lfsr;
  bit       m_sync;
  bit       m_started;   // INIT load done
  bit       m_frozen;    // game is in the frozen phase

  function automatic int lfsr_next(input int v);
    if ((v & 1) != 0) return (v >> 1) ^ 'hB400;
    return v >> 1;
  endfunction

  function automatic int wrap14(input int v);
    int w;
    w = v & 16383;
    if (w >= 8192) w -= 16384;
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pos[k] = -200;
    m_act = '0; m_gap = 2; m_tcnt = 0; m_rcnt = 0; m_period = 4;
    m_lfsr = 'hACE1; m_sync = 0; m_started = 0; m_frozen = 0;
  endtask

  task automatic model_clock();
    int       lf, v, spd;
    bit       is_tick, found;
    bit [3:0] was_free;
    lf     = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    m_sync = 0;
    spd    = int'(dino_speed);
    if (!m_started) begin
      for (int k = 0; k < N; k++) m_pos[k] = -200;
      m_pos[0] = 1200; m_act = 4'b0001; m_gap = 2; m_started = 1;
    end else if (m_frozen) begin
      if (!game_over) m_frozen = 0;
    end else if (game_over) begin
      m_frozen = 1;
    end else begin
      is_tick = (m_tcnt >= m_period - 1);
      if (m_rcnt == 39) begin
        m_rcnt = 0;
        m_period = (m_period - 1 < 2) ? 2 : m_period - 1;
      end else m_rcnt++;
      if (is_tick) begin
        m_tcnt = 0; m_sync = 1;
        was_free = ~m_act;
        for (int k = 0; k < N; k++) if (m_act[k]) begin
          v = wrap14(m_pos[k] + spd);
          if (v >= 4296) begin m_act[k] = 0; m_pos[k] = -200; end
          else m_pos[k] = v;
        end
        if (m_gap > 0) m_gap--;
        else begin
          found = 0;
          for (int k = 0; k < N; k++) if (was_free[k] && !found) begin
            found = 1; m_act[k] = 1; m_pos[k] = -200;
          end
          if (found) m_gap = 2 + (lf & 255);
        end
      end else m_tcnt++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_clock();
  end

  // ---------------- helpers ----------------
  function automatic logic [11:0] slot_pos(input int k);
    return obst_pos[k*PWI +: PWI];
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next obst_sync pulse; reports cycles waited and whether it arrived.
  task automatic wait_sync(input int budget, output bit ok, output int waited);
    ok = 0; waited = 0;
    while (waited < budget && !ok) begin
      @(negedge clk); waited++;
      if (obst_sync) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; dino_speed = 14'd4; game_over = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (obst_active !== 4'b0000) begin n_bad++; $display("FAIL reset_active got=%b exp=0000", obst_active); end
    n_cmp++; if (obst_sync !== 1'b0) begin n_bad++; $display("FAIL reset_sync got=%b exp=0", obst_sync); end
    n_cmp++; if (tick_period !== 32'd4) begin n_bad++; $display("FAIL reset_period got=%0d exp=4", tick_period); end
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (slot_pos(k) !== NEG50) begin n_bad++; $display("FAIL reset_pos%0d got=%h exp=%h", k, slot_pos(k), NEG50); end
    end
  endtask

  task automatic test_first_ticks();
    bit ok; int w;
    dino_speed = 14'd4;
    do_reset();
    @(negedge clk);  // INIT load done
    n_cmp++; if (slot_pos(0) !== 12'd300) begin n_bad++; $display("FAIL init_pos got=%0d exp=300", slot_pos(0)); end
    n_cmp++; if (obst_active !== 4'b0001) begin n_bad++; $display("FAIL init_active got=%b exp=0001", obst_active); end
    wait_sync(20, ok, w);
    n_cmp++; if (!ok || w != 4) begin n_bad++; $display("FAIL first_tick_delay got=%0d ok=%0d exp=4", w, ok); end
    n_cmp++; if (slot_pos(0) !== 12'd301) begin n_bad++; $display("FAIL tick1_pos got=%0d exp=301", slot_pos(0)); end
    wait_sync(20, ok, w);
    n_cmp++; if (!ok || w != 4) begin n_bad++; $display("FAIL tick_spacing got=%0d ok=%0d exp=4", w, ok); end
    n_cmp++; if (slot_pos(0) !== 12'd302) begin n_bad++; $display("FAIL tick2_pos got=%0d exp=302", slot_pos(0)); end
    n_cmp++; if (obst_active !== 4'b0001) begin n_bad++; $display("FAIL tick2_active got=%b exp=0001", obst_active); end
  endtask

  task automatic test_despawn();
    bit ok; int w;
    dino_speed = 14'd1546;   // 386.5 px per tick: 300 -> 686.5 -> 1073
    do_reset();
    wait_sync(20, ok, w);
    wait_sync(20, ok, w);
    n_cmp++; if (!ok || slot_pos(0) !== 12'd1073) begin n_bad++; $display("FAIL near_edge_pos got=%0d exp=1073", slot_pos(0)); end
    dino_speed = 14'd8;
    wait_sync(20, ok, w);
    // Gap expires on this same tick: spawn must go to slot 1, not the just-despawned slot 0
    n_cmp++; if (!ok || obst_active !== 4'b0010) begin n_bad++; $display("FAIL despawn_active got=%b exp=0010", obst_active); end
    n_cmp++; if (slot_pos(0) !== NEG50) begin n_bad++; $display("FAIL despawn_pos got=%h exp=%h", slot_pos(0), NEG50); end
    n_cmp++; if (slot_pos(1) !== NEG50) begin n_bad++; $display("FAIL spawn_pos got=%h exp=%h", slot_pos(1), NEG50); end
  endtask

  task automatic test_defer();
    bit ok; int w;
    dino_speed = 14'd0;
    do_reset();
    for (int i = 0; i < 3000 && !(m_act == 4'b1111 && m_gap == 0); i++) wait_sync(20, ok, w);
    repeat (3) begin
      wait_sync(20, ok, w);
      n_cmp++; if (!ok || obst_active !== 4'b1111) begin n_bad++; $display("FAIL defer_full got=%b exp=1111", obst_active); end
    end
    dino_speed = 14'd3096;   // slot0 300 -> 1074, others -50 -> 724
    wait_sync(20, ok, w);
    dino_speed = 14'd0;
    n_cmp++; if (!ok || obst_active !== 4'b1110) begin n_bad++; $display("FAIL defer_despawn got=%b exp=1110", obst_active); end
    n_cmp++; if (slot_pos(1) !== 12'd724) begin n_bad++; $display("FAIL defer_move got=%0d exp=724", slot_pos(1)); end
    wait_sync(20, ok, w);
    n_cmp++; if (!ok || obst_active !== 4'b1111) begin n_bad++; $display("FAIL defer_respawn got=%b exp=1111", obst_active); end
    n_cmp++; if (slot_pos(0) !== NEG50) begin n_bad++; $display("FAIL defer_respawn_pos got=%h exp=%h", slot_pos(0), NEG50); end
  endtask

  task automatic test_halt();
    bit ok; int w;
    logic [N*PWI-1:0] s_pos; logic [3:0] s_act; logic [31:0] s_per;
    dino_speed = 14'd4;
    do_reset();
    wait_sync(20, ok, w);
    wait_sync(20, ok, w);
    @(negedge clk);            // one RUN clock into the interval
    game_over = 1'b1;
    @(negedge clk);
    s_pos = obst_pos; s_act = obst_active; s_per = tick_period;
    n_cmp++; if (slot_pos(0) !== 12'd302) begin n_bad++; $display("FAIL halt_entry_pos got=%0d exp=302", slot_pos(0)); end
    repeat (10) begin
      @(negedge clk);
      n_cmp++;
      if (obst_pos !== s_pos || obst_active !== s_act || tick_period !== s_per || obst_sync !== 1'b0) begin
        n_bad++; $display("FAIL halt_hold pos=%h act=%b per=%0d sync=%b exp pos=%h act=%b per=%0d sync=0",
                          obst_pos, obst_active, tick_period, obst_sync, s_pos, s_act, s_per);
      end
    end
    game_over = 1'b0;
    wait_sync(20, ok, w);
    // One clock to leave HALT, then two more counts from the held value before the tick
    n_cmp++; if (!ok || w != 4) begin n_bad++; $display("FAIL halt_resume_delay got=%0d exp=4", w); end
    n_cmp++; if (slot_pos(0) !== 12'd303) begin n_bad++; $display("FAIL halt_resume_pos got=%0d exp=303", slot_pos(0)); end
  endtask

  task automatic test_ramp();
    int exp_p;
    dino_speed = 14'd0; game_over = 1'b0;
    do_reset();
    @(negedge clk);            // INIT
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      exp_p = 4 - k / 40;
      if (exp_p < 2) exp_p = 2;
      n_cmp++;
      if (tick_period !== 32'(exp_p)) begin n_bad++; $display("FAIL ramp_period clk=%0d got=%0d exp=%0d", k, tick_period, exp_p); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int w;
    dino_speed = 14'd4;
    do_reset();
    repeat (3) wait_sync(20, ok, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (obst_active !== 4'b0000 || obst_sync !== 1'b0) begin n_bad++; $display("FAIL async_rst act=%b sync=%b exp 0000/0", obst_active, obst_sync); end
    n_cmp++; if (slot_pos(0) !== NEG50) begin n_bad++; $display("FAIL async_rst_pos got=%h exp=%h", slot_pos(0), NEG50); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (obst_active !== 4'b0001 || slot_pos(0) !== 12'd300) begin n_bad++; $display("FAIL rst_init act=%b pos=%0d exp 0001/300", obst_active, slot_pos(0)); end
    // Spawn timing depends on the LFSR restarting from its seed
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++; if (obst_active !== m_act) begin n_bad++; $display("FAIL rst_lfsr_spawn clk=%0d got=%b exp=%b", c, obst_active, m_act); end
    end
  endtask

  task automatic test_random(input int cycles);
    logic [11:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_cmp++; if (obst_active !== m_act) begin n_bad++; $display("FAIL rnd_active clk=%0d got=%b exp=%b", c, obst_active, m_act); end
      n_cmp++; if (obst_sync !== m_sync) begin n_bad++; $display("FAIL rnd_sync clk=%0d got=%b exp=%b", c, obst_sync, m_sync); end
      n_cmp++; if (tick_period !== 32'(m_period)) begin n_bad++; $display("FAIL rnd_period clk=%0d got=%0d exp=%0d", c, tick_period, m_period); end
      for (int k = 0; k < N; k++) begin
        e = 12'(m_pos[k] >>> 2);
        n_cmp++; if (slot_pos(k) !== e) begin n_bad++; $display("FAIL rnd_pos%0d clk=%0d got=%h exp=%h", k, c, slot_pos(k), e); end
      end
      if ($urandom_range(0, 15) == 0) game_over = ~game_over;
      if ($urandom_range(0, 3) == 0)
        dino_speed = ($urandom_range(0, 15) == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 200));
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; game_over = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_ticks();
    test_despawn();
    test_defer();
    test_halt();
    test_ramp();
    test_reset_mid();
    test_random(6000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
